// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register family.
// The stall counter constants only matter when PIPE_STAGE_PERF_EN is defined.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int                     STALL_CNT_W   = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of a pipeline stage: valid flag plus payload and tag.
// Clear beats load and only drops the valid flag; payload is kept.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [TAG_W-1:0]  load_tag,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [TAG_W-1:0]  tag
);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      valid <= 1'b0;
      data  <= '0;
      tag   <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      tag   <= load_tag;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer and flush.
// Define PIPE_STAGE_PERF_EN to add the saturating stall counter (stall_cnt, perf_clr).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
`ifdef PIPE_STAGE_PERF_EN
  ,
  input  logic                   perf_clr,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  pipe_state_e       state, next_state;
  logic              in_fire, out_fire;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data, main_load_data;
  logic [TAG_W-1:0]  skid_tag, main_load_tag;

  // Both handshake outputs come straight from entry flops, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign main_load_data = main_from_skid ? skid_data : in_data;
  assign main_load_tag  = main_from_skid ? skid_tag  : in_tag;

  always_comb begin
    next_state     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      next_state = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            next_state = ST_ONE;
            main_load  = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            next_state = ST_FULL;
            skid_load  = 1'b1;
          end else if (out_fire) begin
            next_state = ST_EMPTY;
            main_clear = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            next_state     = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          next_state = ST_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= ST_EMPTY;
    end else begin
      state <= next_state;
    end
  end

  pipe_entry #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_main (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .clear     (main_clear),
    .load      (main_load),
    .load_data (main_load_data),
    .load_tag  (main_load_tag),
    .valid     (out_valid),
    .data      (out_data),
    .tag       (out_tag)
  );

  pipe_entry #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_skid (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .clear     (skid_clear),
    .load      (skid_load),
    .load_data (in_data),
    .load_tag  (in_tag),
    .valid     (skid_valid),
    .data      (skid_data),
    .tag       (skid_tag)
  );

`ifdef PIPE_STAGE_PERF_EN
  logic [STALL_CNT_W-1:0] stall_q;

  // Clear wins over a same-cycle increment; flush does not touch the count.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      stall_q <= '0;
    end else if (perf_clr) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != STALL_CNT_MAX)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; also checks stall_cnt when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [7:0]  out_tag;
`ifdef PIPE_STAGE_PERF_EN
  logic        perf_clr = 1'b0;
  logic [15:0] stall_cnt;
  logic [15:0] stall_model = '0;
`endif

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] data;
  } item_t;

  item_t sb_q[$];
  int    tests = 0;
  int    failed = 0;
  logic  model_ready = 1'b1;

  pipe_stage_reg dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_clr  (perf_clr),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the queue holds exactly what the stage should contain after the last edge.
  always @(negedge CLK) begin : monitor_p
    int    sz;
    item_t exp_item;
    sz = sb_q.size();
    model_ready = (sz < 2);
    checkOutput("out_valid", 32'(out_valid), 32'(sz > 0));
    checkOutput("in_ready", 32'(in_ready), 32'(sz < 2));
    if (sz > 0 && out_ready) begin
      exp_item = sb_q.pop_front();
      checkOutput("out_data", out_data, exp_item.data);
      checkOutput("out_tag", 32'(out_tag), 32'(exp_item.tag));
    end
`ifdef PIPE_STAGE_PERF_EN
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(stall_model));
    if (!RESET_N || perf_clr) stall_model = '0;
    else if (sz > 0 && !out_ready && stall_model != 16'hFFFF) stall_model = stall_model + 16'd1;
`endif
  end

  // Drive one cycle of inputs, then record what the stage accepts on the coming edge.
  task automatic applyStimulus(input logic iv, input logic [7:0] t, input logic [31:0] d,
                               input logic ordy, input logic fl, input logic rn, input logic pc);
    @(posedge CLK);
    #1;
    in_valid  = iv;
    in_tag    = t;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    RESET_N   = rn;
`ifdef PIPE_STAGE_PERF_EN
    perf_clr  = pc;
`else
    if (pc) $display("[TB] note: perf_clr ignored without counter");
`endif
    @(negedge CLK);
    #1;
    if (!rn || fl) sb_q.delete();
    else if (iv && model_ready) sb_q.push_back(item_t'{tag: t, data: d});
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 8'h00, 32'h0, ordy, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_data", out_data, 32'd0);
    checkOutput("reset_tag", 32'(out_tag), 32'd0);

    // Streaming: one per cycle, one-cycle latency.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 8'(k), 32'(k * 3), 1'b1, 1'b0, 1'b1, 1'b0);
      if (k > 0) begin
        checkOutput("stream_valid", 32'(out_valid), 32'd1);
        checkOutput("stream_tag", 32'(out_tag), 32'(k - 1));
        checkOutput("stream_data", out_data, 32'((k - 1) * 3));
      end
    end
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: four stalled cycles, then resume.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'(8'h20 + k), 32'(32'h100 + k), 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h24, 32'h124, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h25, 32'h125, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_ready_low", 32'(in_ready), 32'd0);
    checkOutput("bp_hold_tag", 32'(out_tag), 32'h23);
    applyStimulus(1'b1, 8'h25, 32'h125, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h25, 32'h125, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h25, 32'h125, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h25, 32'h125, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_ready_back", 32'(in_ready), 32'd1);
    checkOutput("bp_skid_tag", 32'(out_tag), 32'h24);
    for (int k = 6; k < 10; k++) applyStimulus(1'b1, 8'(8'h20 + k), 32'(32'h100 + k), 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush while FULL with a new entry offered.
    applyStimulus(1'b1, 8'h0A, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h0B, 32'hB, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h0C, 32'hC, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_pre_ready", 32'(in_ready), 32'd0);
    checkOutput("flush_pre_tag", 32'(out_tag), 32'h0A);
    idle(1'b1);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_ready", 32'(in_ready), 32'd1);
    idle(1'b1);
    checkOutput("flush_still_empty", 32'(out_valid), 32'd0);

    // Reset while FULL.
    applyStimulus(1'b1, 8'h31, 32'h31, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h32, 32'h32, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h33, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_pre_ready", 32'(in_ready), 32'd0);
    idle(1'b0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_data", out_data, 32'd0);
    checkOutput("rst_tag", 32'(out_tag), 32'd0);

`ifdef PIPE_STAGE_PERF_EN
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'h40, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) idle(1'b0);
    idle(1'b0);
    checkOutput("perf_ten", 32'(stall_cnt), 32'd10);
    for (int k = 0; k < 66000; k++) idle(1'b0);
    checkOutput("perf_sat", 32'(stall_cnt), 32'hFFFF);
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    checkOutput("perf_clr", 32'(stall_cnt), 32'd0);
    idle(1'b1);
`endif

    // Random traffic with occasional flushes.
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), $urandom,
                    1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 49) == 0), 1'b1, 1'b0);
    end
    for (int k = 0; k < 4; k++) idle(1'b1);
    checkOutput("drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
